// File: rtl/adder_pkg.sv
// Shared types and limits for the bit-serial add/subtract controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sac_state_e;

    localparam int SAC_MIN_WIDTH = 2;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, the only arithmetic in the serial controller.
// Latency: combinational.
// Backpressure: none.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
`ifdef INVERT_INPUT_2
    input  logic invert_i_2,
`endif
    output logic sum,
    output logic cout
);

    logic b_eff;

`ifdef INVERT_INPUT_2
    assign b_eff = b ^ invert_i_2;
`else
    assign b_eff = b;
`endif

    // Standard sum/majority-carry equations.
    always_comb begin
        sum  = a ^ b_eff ^ cin;
        cout = (a & b_eff) | (a & cin) | (b_eff & cin);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit add/subtract, one bit per clock LSB first, sharing a single full_adder cell.
// Latency: WIDTH+1 cycles from accept to o_valid; minimum WIDTH+2 cycles per operation.
// Backpressure: o_ready low while busy or holding a result; result held stable in DONE until i_ready.
module serial_add_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int CW = $clog2(WIDTH);

    generate
        if (WIDTH < SAC_MIN_WIDTH) begin : g_width_check
            $error("serial_add_ctrl: WIDTH must be at least SAC_MIN_WIDTH");
        end
    endgenerate

    sac_state_e       state_q;
    sac_state_e       state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cin_msb_q;
    logic [CW-1:0]    cnt_q;
    logic             last_bit;
    logic             fa_sum;
    logic             fa_cout;

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // Single shared cell; subtraction is handled by inverting B at load time.
    full_adder u_fa (
        .a          (a_q[0]),
        .b          (b_q[0]),
        .cin        (carry_q),
`ifdef INVERT_INPUT_2
        .invert_i_2 (1'b0),
`endif
        .sum        (fa_sum),
        .cout       (fa_cout)
    );

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and gated outputs; result ports read zero outside DONE.
    always_comb begin
        state_d    = state_q;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        o_sum      = '0;
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = rst_n;
                if (i_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_valid    = 1'b1;
                o_sum      = sum_q;
                o_carry    = carry_q;
                o_overflow = cin_msb_q ^ carry_q;
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand shift registers, carry and bit counter; load on accept, shift in RUN, hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            cin_msb_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        a_q       <= i_a;
                        b_q       <= i_sub ? ~i_b : i_b;
                        sum_q     <= '0;
                        carry_q   <= i_sub;
                        cin_msb_q <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sum_q   <= {fa_sum, sum_q[WIDTH-1:1]};
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    // Carry entering the MSB is needed for signed overflow.
                    if (last_bit) begin
                        cin_msb_q <= carry_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=32: vector table plus backpressure, noise and reset sequences.
// Latency: n/a.
// Backpressure: exercised by holding i_ready low in DONE.
module tb_serial_add_ctrl;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_sub;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_sum;
    logic         o_carry;
    logic         o_overflow;

    int checks;
    int failures;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_a        (i_a),
        .i_b        (i_b),
        .i_sub      (i_sub),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_sum      (o_sum),
        .o_carry    (o_carry),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle: present a request and let it be accepted.
    // With noise set, i_valid stays high with unrelated operands while the op runs.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input bit noise);
        i_a     = a;
        i_b     = b;
        i_sub   = sub;
        i_valid = 1'b1;
        check("ready_before_accept", {63'd0, o_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        if (noise) begin
            i_a   = 32'hDEAD_BEEF;
            i_b   = 32'h0BAD_F00D;
            i_sub = 1'b1;
        end else begin
            i_valid = 1'b0;
        end
    endtask

    // Called at the negedge after the accept edge. Latency counts the accept cycle,
    // so o_valid is expected on the 33rd cycle for WIDTH=32.
    task automatic wait_done(input logic [W-1:0] exp_sum, input logic exp_c, input logic exp_o);
        int cycles;
        cycles = 1;
        while (!o_valid && cycles < 200) begin
            check("ready_low_while_busy", {63'd0, o_ready}, 64'd0);
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        check("latency", 64'(cycles), 64'(W + 1));
        check("valid", {63'd0, o_valid}, 64'd1);
        check("sum", {32'd0, o_sum}, {32'd0, exp_sum});
        check("carry", {63'd0, o_carry}, {63'd0, exp_c});
        check("overflow", {63'd0, o_overflow}, {63'd0, exp_o});
        check("ready_low_in_done", {63'd0, o_ready}, 64'd0);
    endtask

    // Consume the result and confirm the return to IDLE one cycle later.
    task automatic release_result();
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_ready = 1'b0;
        check("valid_after_release", {63'd0, o_valid}, 64'd0);
        check("ready_after_release", {63'd0, o_ready}, 64'd1);
        check("sum_gated_idle", {32'd0, o_sum}, 64'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_a      = '0;
        i_b      = '0;
        i_sub    = 1'b0;

        //            a             b             sub   sum           carry ovf
        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

        // Reset state, with o_ready forced low while reset is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {63'd0, o_ready}, 64'd0);
        check("rst_valid", {63'd0, o_valid}, 64'd0);
        check("rst_sum", {32'd0, o_sum}, 64'd0);
        check("rst_carry", {63'd0, o_carry}, 64'd0);
        check("rst_ovf", {63'd0, o_overflow}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_rst", {63'd0, o_ready}, 64'd1);

        // i_ready with no result pending does nothing.
        i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_ready = 1'b0;
        check("idle_iready_valid", {63'd0, o_valid}, 64'd0);
        check("idle_iready_ready", {63'd0, o_ready}, 64'd1);

        // Vector table.
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].sub, 1'b0);
            wait_done(vecs[i].sum, vecs[i].carry, vecs[i].ovf);
            release_result();
        end

        // Backpressure: result held 10 cycles while a new request waits.
        issue(32'd10, 32'd20, 1'b0, 1'b0);
        wait_done(32'd30, 1'b0, 1'b0);
        i_a     = 32'd100;
        i_b     = 32'd1;
        i_sub   = 1'b0;
        i_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", {63'd0, o_valid}, 64'd1);
            check("bp_sum", {32'd0, o_sum}, 64'd30);
            check("bp_ready", {63'd0, o_ready}, 64'd0);
        end
        i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_ready = 1'b0;
        check("bp_idle_ready", {63'd0, o_ready}, 64'd1);
        check("bp_idle_valid", {63'd0, o_valid}, 64'd0);
        issue(32'd100, 32'd1, 1'b0, 1'b0);
        wait_done(32'd101, 1'b0, 1'b0);
        release_result();

        // New requests during RUN are ignored.
        issue(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b1);
        wait_done(32'h0000_3333, 1'b0, 1'b0);
        release_result();

        // Reset at RUN bit 12 abandons the operation.
        issue(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrun_rst_valid", {63'd0, o_valid}, 64'd0);
        check("midrun_rst_ready", {63'd0, o_ready}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_valid", {63'd0, o_valid}, 64'd0);
        check("post_rst_ready", {63'd0, o_ready}, 64'd1);
        issue(32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0);
        wait_done(32'h0000_5555, 1'b0, 1'b0);
        release_result();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract controller that time-shares one `full_adder` cell across a `WIDTH`-bit operation, one bit per clock, LSB first. Sits between a requester and a result consumer on valid/ready handshakes. It is the low-area alternative to the ripple `WIDTH`-bit adder in the ALU datapath.

## Interface
- `WIDTH`, default 32: operand and result width, must be at least 2.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `i_valid`  in  1: request valid.
- `o_ready`  out  1: controller can accept a request.
- `i_a`  in  `WIDTH`: operand A.
- `i_b`  in  `WIDTH`: operand B.
- `i_sub`  in  1: 0 computes A+B; 1 computes A−B.
- `o_valid`  out  1: result valid.
- `i_ready`  in  1: consumer accepts the result.
- `o_sum`  out  `WIDTH`: result.
- `o_carry`  out  1: carry-out of the MSB; for subtract, 1 means no borrow.
- `o_overflow`  out  1: signed overflow, equal to carry into MSB XOR carry out of MSB.

## Operation
- FSM states: `IDLE`, `RUN`, `DONE`. Reset state is `IDLE`.
- `IDLE`:
  - `o_ready`=1.
  - On `i_valid`: load shift register `a_q`=`i_a` and `b_q` = `i_sub` ? ~`i_b` : `i_b`.
  - Load `carry_q`=`i_sub`, clear bit counter `cnt_q`, then go to `RUN`.
- `RUN`, each cycle:
  - `full_adder` inputs are `a_q[0]`, `b_q[0]` and `carry_q`.
  - Shift the sum bit into `sum_q` at the MSB, shifting right.
  - Shift `a_q` and `b_q` right. Set `carry_q` to the cell carry. Increment `cnt_q`.
  - On the cycle with `cnt_q`==`WIDTH`-1, capture the incoming `carry_q` as `cin_msb_q` before updating, then go to `DONE`.
- `DONE`:
  - `o_valid`=1.
  - `o_sum`=`sum_q`, `o_carry`=`carry_q`, `o_overflow`=`cin_msb_q` ^ `carry_q`.
  - On `i_ready` return to `IDLE`.
- `o_ready` is 0 in `RUN` and `DONE`. `i_valid` is ignored there and operands are not sampled.
- Outputs are held stable in `DONE` for as long as `i_ready`=0.
- Outside `DONE`: `o_valid`=0, and `o_sum`, `o_carry`, `o_overflow` are 0. The outputs are gated, not raw registers.
- Arithmetic is modulo 2^`WIDTH`. The carry chain is exactly `WIDTH` bits; there is no sign extension.

## Timing
- Reset values (any cycle with `rst_n`=0, effective at that edge):
  - State is `IDLE`; all registers are cleared.
  - `o_valid`=0, `o_sum`=0, `o_carry`=0, `o_overflow`=0.
  - `o_ready` is forced to 0 while `rst_n`=0 and rises in the first cycle after deassertion.
- Latency: if the request is accepted at edge k, `o_valid` is high from the cycle after edge k+`WIDTH`. That is `WIDTH`+1 cycles from accept to valid.
- Throughput: one operation per `WIDTH`+2 cycles minimum (accept, `WIDTH` × `RUN`, at least one `DONE` cycle). There is no accept in the same cycle as the `DONE` handshake.
- Reset mid-`RUN` or mid-`DONE`: the operation is abandoned, with the state after the edge as listed above. No partial result is ever presented.
- `i_ready` high while `o_valid`=0 has no effect.
- `i_valid` may drop without handshake in `IDLE`; this is not an error.

## Structure
- Package `adder_pkg`:
  - typedef enum logic [1:0] `sac_state_e` {`IDLE`, `RUN`, `DONE`}.
  - localparam `SAC_MIN_WIDTH`=2.
- Counter width: `$clog2(WIDTH)`.
- Sub-module: one `full_adder` instance as the only arithmetic.
  - Subtraction inversion is done at load, not in the cell.
  - When `INVERT_INPUT_2` is defined, tie `invert_i_2` to 0.
- Elaboration assertion: `WIDTH` >= `SAC_MIN_WIDTH`.

## Test plan
- `WIDTH`=32, add 0x00000005 + 0x00000003 → `o_sum`=0x00000008, `o_carry`=0, `o_overflow`=0; `o_valid` rises exactly 33 cycles after the accept edge.
- Subtract 5 − 3 → 0x00000002, `o_carry`=1, `o_overflow`=0. Subtract 3 − 5 → 0xFFFFFFFE, `o_carry`=0, `o_overflow`=0.
- Add 0x7FFFFFFF + 1 → 0x80000000, `o_carry`=0, `o_overflow`=1. Add 0xFFFFFFFF + 1 → 0x00000000, `o_carry`=1, `o_overflow`=0. Subtract 0x80000000 − 1 → 0x7FFFFFFF, `o_overflow`=1.
- Backpressure: hold `i_ready`=0 for 10 cycles in `DONE` and drive `i_valid`=1 with new operands. Outputs stay stable, `o_ready`=0, and the new request is not taken. Release `i_ready`: `IDLE` in the next cycle, then the new request is accepted.
- `i_valid`=1 with different operands during `RUN` → result reflects only the originally accepted operands.
- Assert `rst_n`=0 for one cycle at `RUN` bit 12, then release. `o_valid`=0 and `o_ready`=1 next cycle. A following 0x1234 + 0x4321 → 0x5555 with correct latency.
